// File: rtl/clock_pkg.sv
// Shared clock-generation constants and the width helper used to size
// accumulators and counters at elaboration time.
package clock_pkg;

  localparam int SYS_CLK_HZ_DEF = 10_000_000;
  localparam int REF_CLK_HZ_DEF = 32_768;
  localparam int TRIM_W_DEF     = 8;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int width_for(input longint value);
    int     w;
    longint v;
    w = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      w = w + 1;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

  // Accumulator width covering SYS_CLK_HZ plus the largest trimmed increment.
  function automatic int acc_width(input int sys_hz, input int ref_hz, input int trim_w);
    return width_for(longint'(sys_hz) + 2 * longint'(ref_hz) + (longint'(1) << (trim_w - 1)));
  endfunction

endpackage

// File: rtl/refclk_gen_if.sv
// Control and output bundle of refclk_gen. master drives enable/trim and
// observes the clock outputs; slave is the generator side.
interface refclk_gen_if #(
  parameter int TRIM_W = 8
);

  logic              i_en;
  logic              i_trim_stb;
  logic [TRIM_W-1:0] i_trim;
  logic              o_refclk;
  logic              o_refclk_stb;
  logic              o_refclk_1hz_stb;
  logic              o_trim_pending;

  // i_trim_stb is a single-cycle load pulse with no back-pressure: every
  // asserted cycle is taken, and o_trim_pending reports that a value is
  // waiting for the next 1 Hz boundary.
  modport master (
    output i_en,
    output i_trim_stb,
    output i_trim,
    input  o_refclk,
    input  o_refclk_stb,
    input  o_refclk_1hz_stb,
    input  o_trim_pending
  );

  modport slave (
    input  i_en,
    input  i_trim_stb,
    input  i_trim,
    output o_refclk,
    output o_refclk_stb,
    output o_refclk_1hz_stb,
    output o_trim_pending
  );

endinterface

// File: rtl/refclk_nco.sv
// Phase accumulator that toggles a square wave each time the running sum
// crosses SYS_CLK_HZ; the remainder is kept so the rate never drifts.
module refclk_nco #(
  parameter int SYS_CLK_HZ = 1000,
  parameter int ACC_W      = 11
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_refclk,
  output logic             o_rise_d,
  output logic             o_rise
);

  localparam logic [ACC_W:0] SYS_W = (ACC_W + 1)'(SYS_CLK_HZ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             refclk_q;
  logic             refclk_d;
  logic             rise_q;
  logic             rise_d;
  logic [ACC_W:0]   sum;
  logic             wrap;

  // One extra bit keeps acc + inc from wrapping before the compare.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, i_inc};
    wrap     = (sum >= SYS_W);
    acc_d    = acc_q;
    refclk_d = refclk_q;
    rise_d   = 1'b0;
    if (i_en) begin
      if (wrap) begin
        acc_d    = ACC_W'(sum - SYS_W);
        refclk_d = ~refclk_q;
        rise_d   = ~refclk_q;
      end else begin
        acc_d    = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q    <= '0;
      refclk_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      refclk_q <= refclk_d;
      rise_q   <= rise_d;
    end
  end

  assign o_refclk = refclk_q;
  assign o_rise_d = rise_d;
  assign o_rise   = rise_q;

endmodule

// File: rtl/refclk_gen.sv
// Reference clock generator: NCO plus rising-edge counter for the 1 Hz
// strobe and a trim that is only applied on second boundaries.
module refclk_gen
  import clock_pkg::*;
#(
  parameter int SYS_CLK_HZ = SYS_CLK_HZ_DEF,
  parameter int REF_CLK_HZ = REF_CLK_HZ_DEF,
  parameter int TRIM_W     = TRIM_W_DEF
) (
  input  logic   i_clk,
  input  logic   i_reset_n,
  refclk_gen_if.slave bus
);

  localparam int ACC_W = acc_width(SYS_CLK_HZ, REF_CLK_HZ, TRIM_W);
  localparam int CNT_W = width_for(longint'(REF_CLK_HZ));

  localparam logic [ACC_W-1:0] BASE_INC = ACC_W'(2 * REF_CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_CLK_HZ - 1);

  // Every half-period must span at least two system clocks.
  if (2 * (2 * longint'(REF_CLK_HZ) + (longint'(1) << (TRIM_W - 1))) > longint'(SYS_CLK_HZ)) begin : g_rate_check
    $fatal(1, "refclk_gen: REF_CLK_HZ plus trim range too fast for SYS_CLK_HZ");
  end

  logic [TRIM_W-1:0] trim_active_q;
  logic [TRIM_W-1:0] trim_active_d;
  logic [TRIM_W-1:0] trim_pend_q;
  logic [TRIM_W-1:0] trim_pend_d;
  logic              pend_q;
  logic              pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              stb_1hz_q;
  logic              stb_1hz_d;
  logic [ACC_W-1:0]  inc;
  logic              refclk;
  logic              rise_d;
  logic              rise_q;

  assign inc = BASE_INC + {{(ACC_W - TRIM_W){trim_active_q[TRIM_W-1]}}, trim_active_q};

  refclk_nco #(
    .SYS_CLK_HZ(SYS_CLK_HZ),
    .ACC_W     (ACC_W)
  ) u_nco (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (bus.i_en),
    .i_inc    (inc),
    .o_refclk (refclk),
    .o_rise_d (rise_d),
    .o_rise   (rise_q)
  );

  // rise_d is already gated by i_en, so the counter freezes with the NCO.
  always_comb begin
    cnt_d     = cnt_q;
    stb_1hz_d = 1'b0;
    if (rise_d) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        stb_1hz_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + 1'b1;
      end
    end
  end

  // The boundary copy uses the old pending value; a coincident load wins
  // the pending register and keeps the flag set.
  always_comb begin
    trim_active_d = trim_active_q;
    trim_pend_d   = trim_pend_q;
    pend_d        = pend_q;
    if (bus.i_en && stb_1hz_q && pend_q) begin
      trim_active_d = trim_pend_q;
      pend_d        = 1'b0;
    end
    if (bus.i_trim_stb) begin
      trim_pend_d = bus.i_trim;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      trim_active_q <= '0;
      trim_pend_q   <= '0;
      pend_q        <= 1'b0;
      cnt_q         <= '0;
      stb_1hz_q     <= 1'b0;
    end else begin
      trim_active_q <= trim_active_d;
      trim_pend_q   <= trim_pend_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      stb_1hz_q     <= stb_1hz_d;
    end
  end

  assign bus.o_refclk         = refclk;
  assign bus.o_refclk_stb     = rise_q;
  assign bus.o_refclk_1hz_stb = stb_1hz_q;
  assign bus.o_trim_pending   = pend_q;

endmodule

// File: tb/tb_refclk_gen.sv
// Bench for refclk_gen at SYS=1000 Hz, REF=100 Hz: a cumulative-phase model
// predicts every rising edge and the scoreboard matches them as they appear.
module tb_refclk_gen;

  localparam int SYS = 1000;
  localparam int REF = 100;
  localparam int TW  = 8;
  localparam int W   = 33;

  logic clk;
  logic rst_n;

  refclk_gen_if #(.TRIM_W(TW)) bus ();

  refclk_gen #(
    .SYS_CLK_HZ(SYS),
    .REF_CLK_HZ(REF),
    .TRIM_W    (TW)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests;
  int fails;
  int cyc;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Total phase since reset; toggle n happens when phase first reaches n*SYS.
  longint m_phase;
  longint m_toggles;
  int     m_active;
  int     m_pend_val;
  bit     m_pend;
  bit     m_vis;
  bit     m_level;

  task automatic model_reset();
    m_phase    = 0;
    m_toggles  = 0;
    m_active   = 0;
    m_pend_val = 0;
    m_pend     = 0;
    m_vis      = 0;
    m_level    = 0;
  endtask

  task automatic model_step(input bit en, input bit tstb, input logic [TW-1:0] trim);
    longint nt;
    longint rise_no;
    bit     new_1hz;
    bit     old_vis;
    new_1hz = 0;
    old_vis = m_vis;
    if (en) begin
      m_phase = m_phase + longint'(2 * REF + m_active);
      nt = m_phase / SYS;
      if (nt != m_toggles) begin
        m_toggles = nt;
        if ((m_toggles % 2) == 1) begin
          rise_no = (m_toggles + 1) / 2;
          new_1hz = ((rise_no % REF) == 0);
          exp_q.push_back({new_1hz, 32'(cyc + 1)});
        end
      end
    end
    m_level = ((m_toggles % 2) == 1);
    if (en && old_vis && m_pend) begin
      m_active = m_pend_val;
      m_pend   = 0;
    end
    if (tstb) begin
      m_pend_val = int'($signed(trim));
      m_pend     = 1;
    end
    m_vis = new_1hz;
  endtask

  function automatic longint model_rises();
    return (m_toggles + 1) / 2;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  bit             rel_req;
  int             rel_cyc;
  bit             arm_first;
  int             first_rise;
  int             prev_1hz;
  int             last_1hz;
  bit             collide_armed;
  logic [TW-1:0]  collide_val;

  task automatic drive_cycle(input bit en, input bit tstb, input logic [TW-1:0] trim);
    bit             t_stb;
    logic [TW-1:0]  t_val;
    @(negedge clk);
    t_stb = tstb;
    t_val = trim;
    if (rel_req) begin
      rst_n     = 1'b1;
      rel_req   = 0;
      rel_cyc   = cyc;
      arm_first = 1;
    end
    if (collide_armed && bus.o_refclk_1hz_stb) begin
      t_stb         = 1;
      t_val         = collide_val;
      collide_armed = 0;
    end
    bus.i_en       = en;
    bus.i_trim_stb = t_stb;
    bus.i_trim     = t_val;
    if (rst_n) begin
      model_step(en, t_stb, t_val);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      check("refclk_level", bus.o_refclk, m_level);
      check("trim_pending", bus.o_trim_pending, m_pend);
      check("strobe_1hz", bus.o_refclk_1hz_stb, m_vis);
      if (bus.o_refclk_stb) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rise_unexpected: got a rise at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rise_event", {bus.o_refclk_1hz_stb, 32'(cyc)}, 64'(e));
        end
        if (bus.o_refclk_1hz_stb) begin
          prev_1hz = last_1hz;
          last_1hz = cyc;
        end
        if (arm_first) begin
          first_rise = cyc;
          arm_first  = 0;
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) <= cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL rise_missing: got no rise at cycle %0d, expected one", int'(e[31:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    tests = 0; fails = 0; cyc = 0;
    rel_req = 0; arm_first = 0; first_rise = 0;
    prev_1hz = 0; last_1hz = 0;
    collide_armed = 0; collide_val = '0;
    rst_n = 1'b0;
    bus.i_en = 1'b0; bus.i_trim_stb = 1'b0; bus.i_trim = '0;
    model_reset();

    repeat (3) drive_cycle(0, 0, '0);
    check("reset_refclk", bus.o_refclk, 0);
    check("reset_stb", bus.o_refclk_stb, 0);
    check("reset_1hz", bus.o_refclk_1hz_stb, 0);
    check("reset_pending", bus.o_trim_pending, 0);

    // Basic rate, trim 0.
    rel_req = 1;
    repeat (2100) drive_cycle(1, 0, '0);
    check("first_rise_delay", 64'(first_rise - rel_cyc), 5);
    check("basic_1hz_interval", 64'(last_1hz - prev_1hz), 1000);

    // +50 loaded mid-second: period 8, 800-cycle seconds once settled.
    repeat (200) drive_cycle(1, 0, '0);
    drive_cycle(1, 1, 8'd50);
    repeat (2500) drive_cycle(1, 0, '0);
    check("trim_plus_1hz_interval", 64'(last_1hz - prev_1hz), 800);

    // -50 pending, then a +20 load exactly in the boundary cycle.
    drive_cycle(1, 1, 8'hCE);
    collide_val   = 8'd20;
    collide_armed = 1;
    repeat (3300) drive_cycle(1, 0, '0);
    check("collision_hit", collide_armed, 0);

    // Enable dropped for 7 cycles mid-half-period.
    repeat (3) drive_cycle(1, 0, '0);
    repeat (7) drive_cycle(0, 0, '0);
    repeat (500) drive_cycle(1, 0, '0);

    // Randomized enable and trim loads.
    for (int i = 0; i < 4000; i++) begin
      drive_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0),
                  TW'($urandom_range(0, 255)));
    end

    // Asynchronous reset while high and mid-second.
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      drive_cycle(1, 0, '0);
      @(posedge clk);
      #2;
      hit = (bus.o_refclk === 1'b1) && ((model_rises() % REF) != 0);
    end
    check("reset_window_found", hit, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_refclk", bus.o_refclk, 0);
    check("async_rst_stb", bus.o_refclk_stb, 0);
    check("async_rst_1hz", bus.o_refclk_1hz_stb, 0);
    check("async_rst_pending", bus.o_trim_pending, 0);
    model_reset();
    exp_q.delete();
    repeat (3) drive_cycle(1, 0, '0);
    rel_req = 1;
    repeat (1200) drive_cycle(1, 0, '0);
    check("post_reset_first_rise", 64'(first_rise - rel_cyc), 5);

    @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
